div_ctrl: RTL

Multi-cycle divide controller for the RV32M DIV/DIVU/REM/REMU group. ID decodes these instructions with the normal register write disabled. In EX, this block takes the operands, runs a 32-iteration radix-2 restoring division, and holds the pipeline while it works. It owns the shared register-file write port: it merges its own result write with the ordinary EX write request.

---
 rtl/div_ctrl_if.sv | 31 +++
 rtl/div_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_ctrl_if.sv
// Operand, control and register-write signals between the EX stage and div_ctrl.
// master drives the EX-side inputs; slave is the divide controller.
interface div_ctrl_if;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        ex_we_i;
   logic [4:0]  ex_waddr_i;
   logic [31:0] ex_wdata_i;
   logic        hold_o;
   logic        busy_o;
   logic        done_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;

   modport master (
      output start_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
             ex_we_i, ex_waddr_i, ex_wdata_i,
      input  hold_o, busy_o, done_o, reg_we_o, reg_waddr_o, reg_wdata_o
   );

   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
             ex_we_i, ex_waddr_i, ex_wdata_i,
      output hold_o, busy_o, done_o, reg_we_o, reg_waddr_o, reg_wdata_o
   );
endinterface

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU controller: 32-step restoring divider that stalls the
// pipeline and owns the register-file write port, merging its result with EX writes.
module div_ctrl (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_END  = 2'd2
   } state_t;

   state_t      state_r;
   logic [4:0]  cnt_r;
   logic [32:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [4:0]  rd_r;
   logic        is_rem_r;
   logic        qneg_r;
   logic        rneg_r;
   logic        busy_r;

   logic        signed_s;
   logic        div0_s;
   logic        ovf_s;
   logic        special_s;
   logic        accept_s;
   logic        end_write_s;
   logic [31:0] abs_a_s;
   logic [31:0] abs_b_s;
   logic [32:0] trial_s;
   logic        ge_s;
   logic [32:0] diff_s;
   logic [31:0] result_s;

   // Decode the offered instruction and classify its operands.
   always_comb begin
      signed_s  = ~bus.op_i[0];
      div0_s    = (bus.divisor_i == 32'h0000_0000);
      ovf_s     = signed_s && (bus.dividend_i == 32'h8000_0000) &&
                  (bus.divisor_i == 32'hFFFF_FFFF);
      special_s = div0_s | ovf_s;
      accept_s  = (state_r == S_IDLE) && bus.start_i && bus.op_i[2] &&
                  !bus.flush_i && !rst;
      // |0x80000000| wraps back to itself and is then used as an unsigned magnitude
      if (signed_s && bus.dividend_i[31]) begin
         abs_a_s = 32'd0 - bus.dividend_i;
      end else begin
         abs_a_s = bus.dividend_i;
      end
      if (signed_s && bus.divisor_i[31]) begin
         abs_b_s = 32'd0 - bus.divisor_i;
      end else begin
         abs_b_s = bus.divisor_i;
      end
   end

   // One restoring step: shift the next dividend bit in and try the subtraction.
   always_comb begin
      trial_s = {rem_r[31:0], a_r[5'd31 - cnt_r]};
      ge_s    = (trial_s >= {1'b0, b_r});
      diff_s  = trial_s - {1'b0, b_r};
   end

   // Final sign correction of the selected quotient or remainder.
   always_comb begin
      if (is_rem_r) begin
         if (rneg_r) begin
            result_s = 32'd0 - rem_r[31:0];
         end else begin
            result_s = rem_r[31:0];
         end
      end else begin
         if (qneg_r) begin
            result_s = 32'd0 - quo_r;
         end else begin
            result_s = quo_r;
         end
      end
      end_write_s = (state_r == S_END) && !bus.flush_i && !rst;
   end

   // Divider FSM with operand capture and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= S_IDLE;
         cnt_r    <= 5'd0;
         rem_r    <= 33'd0;
         quo_r    <= 32'd0;
         a_r      <= 32'd0;
         b_r      <= 32'd0;
         rd_r     <= 5'd0;
         is_rem_r <= 1'b0;
         qneg_r   <= 1'b0;
         rneg_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else if (bus.flush_i) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  rd_r     <= bus.rd_i;
                  is_rem_r <= bus.op_i[1];
                  a_r      <= abs_a_s;
                  b_r      <= abs_b_s;
                  cnt_r    <= 5'd0;
                  busy_r   <= 1'b1;
                  if (special_s) begin
                     // Special cases preload the final answer with no sign fix-up
                     quo_r   <= div0_s ? 32'hFFFF_FFFF : 32'h8000_0000;
                     rem_r   <= div0_s ? {1'b0, bus.dividend_i} : 33'd0;
                     qneg_r  <= 1'b0;
                     rneg_r  <= 1'b0;
                     state_r <= S_END;
                  end else begin
                     quo_r   <= 32'd0;
                     rem_r   <= 33'd0;
                     qneg_r  <= signed_s & (bus.dividend_i[31] ^ bus.divisor_i[31]);
                     rneg_r  <= signed_s & bus.dividend_i[31];
                     state_r <= S_CALC;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            S_CALC: begin
               rem_r <= ge_s ? diff_s : trial_s;
               quo_r <= {quo_r[30:0], ge_s};
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == 5'd31) begin
                  state_r <= S_END;
               end else begin
                  state_r <= S_CALC;
               end
            end
            S_END: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hold_o      = accept_s || ((state_r == S_CALC) && !bus.flush_i && !rst);
   assign bus.busy_o      = busy_r;
   assign bus.done_o      = end_write_s;
   assign bus.reg_we_o    = rst ? 1'b0 : (end_write_s ? 1'b1 : bus.ex_we_i);
   assign bus.reg_waddr_o = rst ? 5'd0 : (end_write_s ? rd_r : bus.ex_waddr_i);
   assign bus.reg_wdata_o = rst ? 32'd0 : (end_write_s ? result_s : bus.ex_wdata_i);
endmodule
